window_seq: RTL and testbench

WINDOW_SEQ -- requirements
Module: window_seq

---
 rtl/window_seq.sv | 122 ++++++++++++
 tb/tb_window_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_seq.sv
// Frame sequencer for a pipelined window block: gates N samples in, flushes LATENCY stages, counts outputs.
// Define WINDOW_SEQ_OVERRUN_CNT_EN to add a saturating 8-bit overrun_cnt output.
module window_seq #(
  parameter int unsigned N           = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned FRAME_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sample_valid,
  input  logic                   ds_ready,
  input  logic                   win_dvalid,
  output logic                   win_en,
  output logic                   win_clk_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_WIDTH-1:0] frame_idx,
`ifdef WINDOW_SEQ_OVERRUN_CNT_EN
  output logic                   overrun,
  output logic [7:0]             overrun_cnt
`else
  output logic                   overrun
`endif
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned FW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic [FW-1:0] flush_cnt;
  logic          clk_en_q;
  logic          flush_active;
  logic          accept;
  logic          drop;

  // Window strobes are a direct state decode so samples reach the window in their own cycle
  assign flush_active = (state == FLUSH) && (flush_cnt < FW'(LATENCY));
  assign win_en       = (state == RUN);
  assign win_clk_en   = ((state == RUN) && sample_valid) || flush_active;
  assign accept       = start && ds_ready && ((state == IDLE) || (state == DONE));
  assign drop         = start && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      flush_cnt  <= '0;
      clk_en_q   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_idx  <= '0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= drop;
      clk_en_q   <= win_clk_en;
      // dvalid is only meaningful in the cycle after the window was clocked
      if (clk_en_q && win_dvalid && (out_cnt != CW'(N))) begin
        out_cnt <= out_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (sample_valid) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (sample_valid) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == CW'(N - 1)) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (flush_active) begin
            flush_cnt <= flush_cnt + 1'b1;
          end else if (out_cnt == CW'(N)) begin
            state      <= DONE;
            frame_done <= 1'b1;
            frame_idx  <= frame_idx + 1'b1;
          end
        end
        DONE: begin
          in_cnt    <= '0;
          out_cnt   <= '0;
          flush_cnt <= '0;
          state     <= accept ? WAIT : IDLE;
          busy      <= accept;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WINDOW_SEQ_OVERRUN_CNT_EN
  // Saturating count of dropped start requests; survives everything but reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (drop && (overrun_cnt != 8'hFF)) begin
      overrun_cnt <= overrun_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_window_seq.sv
// Scoreboard bench for window_seq: random frames, drops, back-to-back and mid-frame reset.
module tb_window_seq;
  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned FW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic sample_valid = 1'b0;
  logic ds_ready = 1'b0;
  logic win_dvalid;
  logic win_en, win_clk_en, busy, frame_done, overrun;
  logic [FW-1:0] frame_idx;
`ifdef WINDOW_SEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned model_idx = 0;
  int unsigned exp_idx_q[$];
  int unsigned exp_ovr_q[$];
  logic s1 = 1'b0;
  logic s2 = 1'b0;

  window_seq #(.N(N), .LATENCY(LAT), .FRAME_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid),
    .ds_ready(ds_ready), .win_dvalid(win_dvalid), .win_en(win_en),
    .win_clk_en(win_clk_en), .busy(busy), .frame_done(frame_done),
`ifdef WINDOW_SEQ_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .frame_idx(frame_idx), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two-stage window pipeline: valid advances only on clk_en
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else if (win_clk_en) begin
      s1 <= win_en;
      s2 <= s1;
    end
  end
  assign win_dvalid = s2;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame();
    model_idx = (model_idx + 1) % (1 << FW);
    exp_idx_q.push_back(model_idx);
  endtask

  // Monitor: pops expectations whenever the DUT pulses frame_done or overrun
  initial begin
    int run_s = 0;
    int flush_s = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_s = 0;
        flush_s = 0;
      end else begin
        if (win_clk_en && win_en) run_s++;
        if (win_clk_en && !win_en) flush_s++;
        if (overrun) begin
          if (exp_ovr_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL overrun_unexpected actual=1 required=0 (cycle %0d)", cyc);
          end else chk("overrun_cycle", cyc, exp_ovr_q.pop_front());
        end
        if (frame_done) begin
          if (exp_idx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL frame_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
          end else begin
            chk("frame_idx", frame_idx, exp_idx_q.pop_front());
            chk("run_strobes", run_s, N);
            chk("flush_strobes", flush_s, LAT);
          end
          run_s = 0;
          flush_s = 0;
        end
      end
    end
  end

  task automatic idle_drop();
    start = 1'b1;
    ds_ready = 1'b0;
    exp_ovr_q.push_back(cyc + 1);
    tick();
    start = 1'b0;
    chk("busy_after_drop", busy, 0);
  endtask

  // One frame: optional start from IDLE, N+1 sample pulses (first unconsumed), then flush/done
  task automatic do_frame(input bit from_idle, input int gap, input bit extra,
                          input int rst_at, input bit b2b);
    bit done;
    if (from_idle) begin
      start = 1'b1;
      ds_ready = 1'b1;
      expect_frame();
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
    end
    for (int j = 0; j <= int'(N); j++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        sample_valid = 1'b0;
        ds_ready = 1'($urandom_range(0, 1));
        start = extra && ($urandom_range(0, 5) == 0);
        if (start) exp_ovr_q.push_back(cyc + 1);
        tick();
        start = 1'b0;
      end
      if (rst_at >= 0 && j == rst_at + 1) begin
        sample_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_win_en", win_en, 0);
        chk("rst_win_clk_en", win_clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_idx", frame_idx, 0);
        exp_idx_q.delete();
        model_idx = 0;
        tick();
        tick();
        rst = 1'b0;
        sample_valid = 1'b0;
        tick();
        return;
      end
      sample_valid = 1'b1;
      start = extra && (j == 5 || $urandom_range(0, 5) == 0);
      if (start) exp_ovr_q.push_back(cyc + 1);
      #1;
      chk("pulse_win_en", win_en, (j > 0));
      chk("pulse_win_clk_en", win_clk_en, (j > 0));
      tick();
      start = 1'b0;
      sample_valid = 1'b0;
    end
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      sample_valid = 1'($urandom_range(0, 1));
      ds_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (frame_done) done = 1'b1;
      else tick();
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL frame_done_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
    sample_valid = 1'b0;
    if (b2b) begin
      start = 1'b1;
      ds_ready = 1'b1;
      expect_frame();
    end
    tick();
    start = 1'b0;
    chk("busy_after_done", busy, b2b);
  endtask

  initial begin
    bit prev_b2b;
    bit b2b;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_frame_idx", frame_idx, 0);
    chk("reset_win_en", win_en, 0);
    chk("reset_win_clk_en", win_clk_en, 0);
    rst = 1'b0;
    tick();

    idle_drop();
    tick();
    chk("busy_idle_stays", busy, 0);

    do_frame(1'b1, 2, 1'b0, -1, 1'b0);
    do_frame(1'b1, -1, 1'b1, -1, 1'b1);
    do_frame(1'b0, -1, 1'b0, -1, 1'b0);
    do_frame(1'b1, 1, 1'b0, 5, 1'b0);
    do_frame(1'b1, -1, 1'b0, -1, 1'b0);

    prev_b2b = 1'b0;
    for (int f = 0; f < 6; f++) begin
      if (!prev_b2b && $urandom_range(0, 1) == 1) idle_drop();
      b2b = (f != 5) && ($urandom_range(0, 1) == 1);
      do_frame(!prev_b2b, -1, 1'b1, -1, b2b);
      prev_b2b = b2b;
    end

`ifdef WINDOW_SEQ_OVERRUN_CNT_EN
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_overrun_cnt", overrun_cnt, 0);
    rst = 1'b0;
    model_idx = 0;
    tick();
    for (int i = 0; i < 300; i++) begin
      start = 1'b1;
      ds_ready = 1'b0;
      exp_ovr_q.push_back(cyc + 1);
      tick();
    end
    start = 1'b0;
    tick();
    tick();
    chk("overrun_cnt_sat", overrun_cnt, 255);
`endif

    repeat (4) tick();
    chk("pending_frame_done", exp_idx_q.size(), 0);
    chk("pending_overrun", exp_ovr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
